stack_unit: RTL

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_unit_pkg.sv | 38 +++
 rtl/stack_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/stack_unit_pkg.sv
// Shared control definitions for the stack unit: FSM encoding, default stack
// bounds, flag bit positions and frame bound checks.
package stack_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WR_PC,
        WR_FLG,
        RD_FLG,
        RD_PC,
        DONE
    } state_t;

    localparam logic [7:0] STACK_TOP_DEFAULT   = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEFAULT = 8'hE0;

    localparam int unsigned FLAG_V  = 0;
    localparam int unsigned FLAG_N  = 1;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_Z  = 3;
    localparam int unsigned FLAG_IF = 4;
    localparam int unsigned FLAG_IE = 5;

    localparam logic [7:0] FLAG_MASK = (8'd1 << FLAG_V)  | (8'd1 << FLAG_N)  |
                                       (8'd1 << FLAG_C)  | (8'd1 << FLAG_Z)  |
                                       (8'd1 << FLAG_IF) | (8'd1 << FLAG_IE);

    // Checks are done in 9 bits so the two-byte frame can never wrap SP.
    function automatic logic push_fits(input logic [7:0] sp, input logic [7:0] limit);
        return {1'b0, sp} >= ({1'b0, limit} + 9'd2);
    endfunction

    function automatic logic pop_fits(input logic [7:0] sp, input logic [7:0] top);
        return ({1'b0, sp} + 9'd2) <= {1'b0, top};
    endfunction

endpackage

// File: rtl/stack_unit.sv
// Hardware call stack: pushes/pops a {PC, flags} frame to data memory over a
// shared bus, with sticky overflow/underflow detection.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEFAULT,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stack_op_ongoing,
    input  logic       push_or_pop,
    input  logic [7:0] push_pc,
    input  logic [7:0] push_flags,
    output logic       stack_op_end,
    output logic [7:0] return_addr,
    output logic [7:0] flags_dout,
    output logic [7:0] sp,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic [7:0] mem_addr,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic [7:0] mem_dout,
    input  logic [7:0] mem_din,
    output logic       stack_ovf,
    output logic       stack_unf
);

    state_t     state_q, state_d;
    logic [7:0] sp_q;
    logic       is_push_q;
    logic [7:0] pc_q;
    logic [7:0] flags_q;
    logic [7:0] ret_q;
    logic [7:0] flg_q;
    logic       ovf_q;
    logic       unf_q;
    logic       op_rejected;

    always_comb begin
        op_rejected = is_push_q ? !push_fits(sp_q, STACK_LIMIT)
                                : !pop_fits(sp_q, STACK_TOP);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stack_op_ongoing) state_d = REQ;
            REQ:     if (bus_grant) begin
                         if (op_rejected)    state_d = DONE;
                         else if (is_push_q) state_d = WR_PC;
                         else                state_d = RD_FLG;
                     end
            WR_PC:   if (bus_grant) state_d = WR_FLG;
            WR_FLG:  if (bus_grant) state_d = DONE;
            RD_FLG:  if (bus_grant) state_d = RD_PC;
            RD_PC:   if (bus_grant) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are masked by rst so a mid-operation reset issues no further access.
    always_comb begin
        bus_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = sp_q;
        mem_dout     = '0;
        stack_op_end = 1'b0;
        if (!rst) begin
            case (state_q)
                REQ:    bus_req = 1'b1;
                WR_PC: begin
                    bus_req  = 1'b1;
                    mem_wr   = bus_grant;
                    mem_addr = sp_q - 8'd1;
                    mem_dout = pc_q;
                end
                WR_FLG: begin
                    bus_req  = 1'b1;
                    mem_wr   = bus_grant;
                    mem_addr = sp_q - 8'd2;
                    mem_dout = flags_q;
                end
                RD_FLG: begin
                    bus_req  = 1'b1;
                    mem_rd   = bus_grant;
                    mem_addr = sp_q;
                end
                RD_PC: begin
                    bus_req  = 1'b1;
                    mem_rd   = bus_grant;
                    mem_addr = sp_q + 8'd1;
                end
                DONE:    stack_op_end = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q      <= STACK_TOP;
            is_push_q <= 1'b0;
            pc_q      <= '0;
            flags_q   <= '0;
            ret_q     <= '0;
            flg_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (stack_op_ongoing) begin
                    is_push_q <= push_or_pop;
                    pc_q      <= push_pc;
                    flags_q   <= push_flags & FLAG_MASK;
                end
                REQ: if (bus_grant && op_rejected) begin
                    if (is_push_q) ovf_q <= 1'b1;
                    else           unf_q <= 1'b1;
                end
                WR_FLG: if (bus_grant) sp_q <= sp_q - 8'd2;
                RD_FLG: if (bus_grant) flg_q <= mem_din;
                RD_PC: if (bus_grant) begin
                    ret_q <= mem_din;
                    sp_q  <= sp_q + 8'd2;
                end
                default: ;
            endcase
        end
    end

    assign sp          = sp_q;
    assign return_addr = ret_q;
    assign flags_dout  = flg_q;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;

endmodule
